// File: rtl/fme_pkg.sv
// Shared types and constants for the fractional motion estimation SAD selector.
package fme_pkg;

    localparam int unsigned DATAWIDTH_DEF = 8;
    localparam int unsigned ROW_PIX_DEF   = 8;
    localparam int unsigned ROWS_DEF      = 8;
    localparam int unsigned NUM_CAND_DEF  = 8;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        FLUSH,
        DONE
    } fme_state_e;

    // Smallest accumulator width that cannot overflow for a block of pix pixels.
    function automatic int unsigned sad_w_calc(input int unsigned dw, input int unsigned pix);
        return dw + $clog2(pix);
    endfunction

endpackage

// File: rtl/fme_row_sad.sv
// Combinational sum of absolute differences across one row of pixels.
module fme_row_sad #(
    parameter int unsigned DATAWIDTH = 8,
    parameter int unsigned ROW_PIX   = 8
) (
    input  logic [ROW_PIX*DATAWIDTH-1:0]            cand_row,
    input  logic [ROW_PIX*DATAWIDTH-1:0]            orig_row,
    output logic [DATAWIDTH+$clog2(ROW_PIX)-1:0]    row_sad
);

    localparam int unsigned OUT_W = DATAWIDTH + $clog2(ROW_PIX);

    logic [DATAWIDTH:0]   diff [ROW_PIX];
    logic [DATAWIDTH-1:0] mag  [ROW_PIX];
    logic [OUT_W-1:0]     sum;

    // Sign bit of the widened difference selects the magnitude.
    for (genvar k = 0; k < ROW_PIX; k++) begin : g_pix
        assign diff[k] = {1'b0, cand_row[k*DATAWIDTH +: DATAWIDTH]}
                       - {1'b0, orig_row[k*DATAWIDTH +: DATAWIDTH]};
        assign mag[k]  = diff[k][DATAWIDTH] ? DATAWIDTH'(-diff[k])
                                            : diff[k][DATAWIDTH-1:0];
    end

    always_comb begin
        sum = '0;
        for (int k = 0; k < ROW_PIX; k++) begin
            sum = sum + OUT_W'(mag[k]);
        end
    end

    assign row_sad = sum;

endmodule

// File: rtl/fme_sad_selector.sv
// Accumulates per-candidate 8x8 SADs from streamed rows and keeps the lowest.
module fme_sad_selector
    import fme_pkg::*;
#(
    parameter int unsigned DATAWIDTH = DATAWIDTH_DEF,
    parameter int unsigned ROW_PIX   = ROW_PIX_DEF,
    parameter int unsigned ROWS      = ROWS_DEF,
    parameter int unsigned NUM_CAND  = NUM_CAND_DEF,
    parameter int unsigned SAD_W     = sad_w_calc(DATAWIDTH, ROW_PIX*ROWS)
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          start,
    input  logic                          in_valid,
    input  logic [ROW_PIX*DATAWIDTH-1:0]  cand_row,
    input  logic [ROW_PIX*DATAWIDTH-1:0]  orig_row,
    output logic                          busy,
    output logic                          done,
    output logic [$clog2(NUM_CAND)-1:0]   best_idx,
    output logic [SAD_W-1:0]              best_sad
);

    localparam int unsigned RS_W = DATAWIDTH + $clog2(ROW_PIX);
    localparam int unsigned RC_W = $clog2(ROWS);
    localparam int unsigned CI_W = $clog2(NUM_CAND);

    fme_state_e       state, state_next;
    logic [RC_W-1:0]  row_cnt;
    logic [CI_W-1:0]  cand_cnt;
    logic [RS_W-1:0]  row_sad;
    logic             s1_valid;
    logic             s1_last;
    logic [CI_W-1:0]  s1_cand;
    logic [RS_W-1:0]  s1_sad;
    logic [SAD_W-1:0] acc;
    logic [SAD_W-1:0] cand_sad;
    logic             accept;
    logic             row_last;
    logic             pass_last;
    logic             start_ok;

    fme_row_sad #(
        .DATAWIDTH (DATAWIDTH),
        .ROW_PIX   (ROW_PIX)
    ) u_row_sad (
        .cand_row (cand_row),
        .orig_row (orig_row),
        .row_sad  (row_sad)
    );

    assign accept    = (state == ACCUM) && in_valid;
    assign row_last  = (row_cnt == RC_W'(ROWS - 1));
    assign pass_last = row_last && (cand_cnt == CI_W'(NUM_CAND - 1));
    assign start_ok  = start && ((state == IDLE) || (state == DONE));
    assign cand_sad  = acc + SAD_W'(s1_sad);

    always_comb begin
        state_next = state;
        case (state)
            IDLE, DONE: if (start) state_next = ACCUM;
            ACCUM:      if (accept && pass_last) state_next = FLUSH;
            FLUSH:      state_next = DONE;
            default:    state_next = IDLE;
        endcase
    end

    // done fires on the FLUSH->DONE transition, i.e. one cycle after the last row retires.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_next;
            busy  <= (state_next == ACCUM) || (state_next == FLUSH);
            done  <= (state == FLUSH);
        end
    end

    // Row/candidate counters and the stage-1 register of the row SAD.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            row_cnt  <= '0;
            cand_cnt <= '0;
            s1_valid <= 1'b0;
            s1_last  <= 1'b0;
            s1_cand  <= '0;
            s1_sad   <= '0;
        end else if (start_ok) begin
            row_cnt  <= '0;
            cand_cnt <= '0;
            s1_valid <= 1'b0;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                s1_sad  <= row_sad;
                s1_last <= row_last;
                s1_cand <= cand_cnt;
                if (row_last) begin
                    row_cnt <= '0;
                    if (!pass_last) cand_cnt <= cand_cnt + 1'b1;
                end else begin
                    row_cnt <= row_cnt + 1'b1;
                end
            end
        end
    end

    // Stage 2: accumulate, then compare at each candidate boundary; ties keep the older index.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            acc      <= '0;
            best_idx <= '0;
            best_sad <= '1;
        end else if (start_ok) begin
            acc <= '0;
        end else if (s1_valid) begin
            if (s1_last) begin
                acc <= '0;
                if ((s1_cand == '0) || (cand_sad < best_sad)) begin
                    best_idx <= s1_cand;
                    best_sad <= cand_sad;
                end
            end else begin
                acc <= cand_sad;
            end
        end
    end

endmodule
